// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: LANES-wide FP32 multiplier, three register stages
// (unpack / significand product / normalise-round-pack), whole-pipe stall,
// sideband tag, per-lane {underflow, overflow, invalid} flags.
module fp_mult_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*32-1:0]  in_w,
    input  logic [LANES*32-1:0]  in_x,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*32-1:0]  out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [LANES*3-1:0]   out_flags
);

    // Stage 1 payload: operands unpacked, special result already resolved.
    typedef struct packed {
        logic        sign;
        logic        spec;
        logic        inv;
        logic [31:0] spec_val;
        logic [9:0]  exp;       // two's complement, ew+ex-127
        logic [23:0] mw;
        logic [23:0] mx;
    } s1_t;

    // Stage 2 payload: full-width significand product.
    typedef struct packed {
        logic        sign;
        logic        spec;
        logic        inv;
        logic [31:0] spec_val;
        logic [9:0]  exp;
        logic [47:0] prod;
    } s2_t;

    // Stage 3 payload: packed result and flags {underflow, overflow, invalid}.
    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;
    } s3_t;

    function automatic s1_t unpack_lane(input logic [31:0] w, input logic [31:0] x);
        s1_t  r;
        logic w_nan, x_nan, w_snan, x_snan, w_inf, x_inf, w_zero, x_zero, inf_zero;
        w_nan    = (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
        x_nan    = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        w_snan   = w_nan && !w[22];
        x_snan   = x_nan && !x[22];
        w_inf    = (w[30:23] == 8'hFF) && (w[22:0] == 23'd0);
        x_inf    = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        // Exponent 0 is flushed to zero regardless of mantissa.
        w_zero   = (w[30:23] == 8'h00);
        x_zero   = (x[30:23] == 8'h00);
        inf_zero = (w_inf && x_zero) || (x_inf && w_zero);

        r          = '0;
        r.sign     = w[31] ^ x[31];
        r.exp      = {2'b00, w[30:23]} + {2'b00, x[30:23]} - 10'd127;
        r.mw       = {1'b1, w[22:0]};
        r.mx       = {1'b1, x[22:0]};
        if (w_nan || x_nan || inf_zero) begin
            r.spec     = 1'b1;
            r.spec_val = 32'h7FC0_0000;
            r.inv      = inf_zero || w_snan || x_snan;
        end else if (w_inf || x_inf) begin
            r.spec     = 1'b1;
            r.spec_val = {r.sign, 8'hFF, 23'd0};
        end else if (w_zero || x_zero) begin
            r.spec     = 1'b1;
            r.spec_val = {r.sign, 31'd0};
        end
        return r;
    endfunction

    function automatic s2_t mult_lane(input s1_t a);
        s2_t r;
        r.sign     = a.sign;
        r.spec     = a.spec;
        r.inv      = a.inv;
        r.spec_val = a.spec_val;
        r.exp      = a.exp;
        r.prod     = 48'(a.mw) * 48'(a.mx);
        return r;
    endfunction

    function automatic s3_t round_lane(input s2_t a);
        s3_t               r;
        logic signed [9:0] e;
        logic [23:0]       sig;
        logic              guard, sticky, rnd;
        logic [24:0]       sum;
        r = '0;
        if (a.spec) begin
            r.res   = a.spec_val;
            r.flags = {2'b00, a.inv};
        end else begin
            e = a.exp;
            if (a.prod[47]) begin
                sig    = a.prod[47:24];
                guard  = a.prod[23];
                sticky = |a.prod[22:0];
                e      = e + 10'sd1;
            end else begin
                sig    = a.prod[46:23];
                guard  = a.prod[22];
                sticky = |a.prod[21:0];
            end
            rnd = guard && (sticky || sig[0]);
            sum = {1'b0, sig} + {24'd0, rnd};
            // Carry out of rounding means the significand became 2.0.
            if (sum[24]) begin
                sig = sum[24:1];
                e   = e + 10'sd1;
            end else begin
                sig = sum[23:0];
            end
            if (e >= 10'sd255) begin
                r.res   = {a.sign, 8'hFF, 23'd0};
                r.flags = 3'b010;
            end else if (e <= 10'sd0) begin
                r.res   = {a.sign, 31'd0};
                r.flags = 3'b100;
            end else begin
                r.res   = {a.sign, e[7:0], sig[22:0]};
                r.flags = 3'b000;
            end
        end
        return r;
    endfunction

    logic             advance;
    logic             v1, v2, v3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    s1_t              s1_q [LANES];
    s2_t              s2_q [LANES];
    s3_t              s3_q [LANES];
    s1_t              s1_d [LANES];
    s2_t              s2_d [LANES];
    s3_t              s3_d [LANES];

    assign advance   = !v3 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v3;
    assign out_tag   = tag3;

    // Per-lane datapath between the stage registers.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_d[i] = unpack_lane(in_w[32*i +: 32], in_x[32*i +: 32]);
            s2_d[i] = mult_lane(s1_q[i]);
            s3_d[i] = round_lane(s2_q[i]);
        end
    end

    // Flatten the output stage onto the packed result and flag buses.
    always_comb begin
        out_result = '0;
        out_flags  = '0;
        for (int i = 0; i < LANES; i++) begin
            out_result[32*i +: 32] = s3_q[i].res;
            out_flags[3*i +: 3]    = s3_q[i].flags;
        end
    end

    // Pipeline registers: reset clears everything, otherwise shift on advance.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            tag1 <= '0;
            tag2 <= '0;
            tag3 <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_q[i] <= '0;
                s2_q[i] <= '0;
                s3_q[i] <= '0;
            end
        end else if (advance) begin
            v1   <= in_valid;
            v2   <= v1;
            v3   <= v2;
            tag1 <= in_tag;
            tag2 <= tag1;
            tag3 <= tag2;
            for (int i = 0; i < LANES; i++) begin
                s1_q[i] <= s1_d[i];
                s2_q[i] <= s2_d[i];
                s3_q[i] <= s3_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vector table plus handshake corner sequences.
module tb_fp_mult_pipe;

    localparam int LANES = 4;
    localparam int TAG_W = 32;
    localparam int NV    = 6;

    logic                clk = 1'b0;
    logic                rstn;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*32-1:0] in_w;
    logic [LANES*32-1:0] in_x;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*32-1:0] out_result;
    logic [TAG_W-1:0]    out_tag;
    logic [LANES*3-1:0]  out_flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] w;
        logic [127:0] x;
        logic [127:0] r;
        logic [11:0]  f;
    } vec_t;

    vec_t vecs [NV];

    fp_mult_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_w       (in_w),
        .in_x       (in_x),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_flags  (out_flags)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence never terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Lane pattern for streamed beats: 2.0 * 2^tag = 2^(tag+1).
    function automatic logic [127:0] stream_x(input int t);
        logic [31:0] v;
        v = 32'h3F80_0000 + (32'(t) << 23);
        return {v, v, v, v};
    endfunction

    function automatic logic [127:0] stream_r(input int t);
        logic [31:0] v;
        v = 32'h4000_0000 + (32'(t) << 23);
        return {v, v, v, v};
    endfunction

    logic [127:0] held_res;
    logic [31:0]  held_tag;
    logic [11:0]  held_flags;
    logic         stalled_prev;
    int           next_tag;
    int           got;

    initial begin
        // Lane order in each concatenation: {lane3, lane2, lane1, lane0}.
        // Flags per lane: {underflow, overflow, invalid}.
        vecs[0].w = {32'h3F800001, 32'h3FC00000, 32'hC0000000, 32'h40000000};
        vecs[0].x = {32'h3F800001, 32'h3FC00000, 32'h40400000, 32'h40400000};
        vecs[0].r = {32'h3F800002, 32'h40100000, 32'hC0C00000, 32'h40C00000};
        vecs[0].f = {3'b000, 3'b000, 3'b000, 3'b000};
        vecs[1].w = {32'h7F800000, 32'h00800000, 32'h7F7FFFFF, 32'h3FFFFFFF};
        vecs[1].x = {32'h00000000, 32'h00800000, 32'h40000000, 32'h3FFFFFFF};
        vecs[1].r = {32'h7FC00000, 32'h00000000, 32'h7F800000, 32'h407FFFFE};
        vecs[1].f = {3'b001, 3'b100, 3'b010, 3'b000};
        vecs[2].w = {32'hFF800000, 32'h7FC00000, 32'h7FA00000, 32'h80000000};
        vecs[2].x = {32'h40000000, 32'h00000000, 32'h3F800000, 32'h40000000};
        vecs[2].r = {32'hFF800000, 32'h7FC00000, 32'h7FC00000, 32'h80000000};
        vecs[2].f = {3'b000, 3'b000, 3'b001, 3'b000};
        vecs[3].w = {32'h3F7FFFFE, 32'h3F800001, 32'h80000001, 32'h00400000};
        vecs[3].x = {32'h3F800001, 32'h3FC00000, 32'h3F800000, 32'h40000000};
        vecs[3].r = {32'h3F800000, 32'h3FC00002, 32'h80000000, 32'h00000000};
        vecs[3].f = {3'b000, 3'b000, 3'b000, 3'b000};
        vecs[4].w = {32'h80800000, 32'hFF000000, 32'h7F000000, 32'h3F800003};
        vecs[4].x = {32'h00800000, 32'h7F000000, 32'h7F000000, 32'h3FC00000};
        vecs[4].r = {32'h80000000, 32'hFF800000, 32'h7F800000, 32'h3FC00004};
        vecs[4].f = {3'b100, 3'b010, 3'b010, 3'b000};
        vecs[5].w = {32'h7F800000, 32'h7F000000, 32'h20000000, 32'h20000000};
        vecs[5].x = {32'hFF800000, 32'h3F800000, 32'h20000000, 32'h1F800000};
        vecs[5].r = {32'hFF800000, 32'h7F000000, 32'h00800000, 32'h00000000};
        vecs[5].f = {3'b000, 3'b000, 3'b000, 3'b100};

        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_w      = '0;
        in_x      = '0;
        in_tag    = '0;
        out_ready = 1'b0;

        // Reset, then first cycle after release.
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_out_result", 128'(out_result), 128'd0);
        chk("rst_out_tag", 128'(out_tag), 128'd0);
        chk("rst_out_flags", 128'(out_flags), 128'd0);

        // Vector table streamed back-to-back; each row must appear on the
        // third rising edge after it is presented, and not earlier.
        @(negedge clk);
        out_ready = 1'b1;
        for (int j = 0; j < NV + 3; j++) begin
            if (j < NV) begin
                in_valid = 1'b1;
                in_w     = vecs[j].w;
                in_x     = vecs[j].x;
                in_tag   = 32'hA000_0000 + 32'(j);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j >= 2 && j - 2 < NV) begin
                chk("vec_valid", 128'(out_valid), 128'd1);
                chk("vec_result", out_result, vecs[j-2].r);
                chk("vec_flags", 128'(out_flags), 128'(vecs[j-2].f));
                chk("vec_tag", 128'(out_tag), 128'(32'hA000_0000 + 32'(j - 2)));
            end else begin
                chk("vec_latency_idle", 128'(out_valid), 128'd0);
            end
        end

        // Backpressure: tags 1..10, out_ready high one cycle in three.
        next_tag     = 1;
        got          = 0;
        stalled_prev = 1'b0;
        held_res     = '0;
        held_tag     = '0;
        held_flags   = '0;
        for (int c = 0; c < 300 && got < 10; c++) begin
            out_ready = (c % 3 == 0);
            if (next_tag <= 10) begin
                in_valid = 1'b1;
                in_tag   = 32'(next_tag);
                in_w     = {4{32'h4000_0000}};
                in_x     = stream_x(next_tag);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready)
                chk("bp_in_ready_full", 128'(in_ready), 128'd0);
            if (stalled_prev) begin
                chk("bp_hold_result", out_result, held_res);
                chk("bp_hold_tag", 128'(out_tag), 128'(held_tag));
                chk("bp_hold_flags", 128'(out_flags), 128'(held_flags));
            end
            if (out_valid && out_ready) begin
                got++;
                chk("bp_tag_order", 128'(out_tag), 128'(got));
                chk("bp_result", out_result, stream_r(got));
            end
            stalled_prev = out_valid && !out_ready;
            held_res     = out_result;
            held_tag     = out_tag;
            held_flags   = out_flags;
            if (in_valid && in_ready)
                next_tag++;
            @(negedge clk);
        end
        chk("bp_count", 128'(got), 128'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_no_dup", 128'(out_valid), 128'd0);
            @(negedge clk);
        end

        // Full throughput: 16 back-to-back beats, 16 consecutive outputs.
        out_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            if (j < 16) begin
                in_valid = 1'b1;
                in_tag   = 32'(100 + j);
                in_w     = {4{32'h4000_0000}};
                in_x     = stream_x(j % 8);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (j >= 2 && j < 18) begin
                chk("tp_valid", 128'(out_valid), 128'd1);
                chk("tp_tag", 128'(out_tag), 128'(100 + j - 2));
                chk("tp_result", out_result, stream_r((j - 2) % 8));
            end else begin
                chk("tp_idle", 128'(out_valid), 128'd0);
            end
        end

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_tag   = 32'(200 + j);
            in_w     = vecs[0].w;
            in_x     = vecs[0].x;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("mrst_out_valid", 128'(out_valid), 128'd0);
        chk("mrst_out_result", 128'(out_result), 128'd0);
        chk("mrst_out_tag", 128'(out_tag), 128'd0);
        chk("mrst_out_flags", 128'(out_flags), 128'd0);
        chk("mrst_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("mrst_no_stale", 128'(out_valid), 128'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
